imem_boot_loader: RTL

//  Upstream boot stage for the single-cycle RISC-V core. Accepts a byte stream (UART/debug link),

---
 rtl/imem_boot_loader_if.sv | 24 ++
 rtl/imem_boot_loader.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader_if.sv
// Byte-stream and instruction-memory write bundle for imem_boot_loader.
// The loader sits on the slave side; the boot host/bench sits on the master side.
interface imem_boot_loader_if;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        done;
  logic        error;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, imem_we, imem_addr, imem_wdata, core_rst, done, error
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, imem_we, imem_addr, imem_wdata, core_rst, done, error
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: assembles little-endian words from a byte stream into instruction memory and
// holds the core in reset until the image is loaded. IMEM_BOOT_CHECKSUM_EN adds a trailing XOR byte.
module imem_boot_loader #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input logic               clk,
  input logic               rst,
  imem_boot_loader_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR0 = 3'd1;
  localparam logic [2:0] S_HDR1 = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;
`ifdef IMEM_BOOT_CHECKSUM_EN
  localparam logic [2:0] S_CSUM = 3'd6;
  // Where a complete image goes next: through the checksum byte, or straight to DONE.
  localparam logic [2:0] S_FIN  = S_CSUM;
`else
  localparam logic [2:0] S_FIN  = S_DONE;
`endif

  logic [2:0]  state_q,      state_d;
  logic [15:0] count_q,      count_d;
  logic [15:0] word_idx_q,   word_idx_d;
  logic [1:0]  byte_idx_q,   byte_idx_d;
  logic [23:0] shift_q,      shift_d;
  logic        byte_ready_q, byte_ready_d;
  logic        we_q,         we_d;
  logic [31:0] addr_q,       addr_d;
  logic [31:0] wdata_q,      wdata_d;
  logic        core_rst_q,   core_rst_d;
  logic        done_q,       done_d;
  logic        error_q,      error_d;
  logic [7:0]  csum_q,       csum_d;
  logic        accept;
  logic [15:0] hdr_count;

  assign accept    = bus.byte_valid & byte_ready_q;
  assign hdr_count = {bus.byte_in, count_q[7:0]};

  always_comb begin
    // NOTE: every next-state value gets a default first, so no path through the case infers a latch.
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    core_rst_d = core_rst_q;
    done_d     = done_q;
    error_d    = error_q;
    csum_d     = csum_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (state_q == S_DONE) begin
          done_d     = 1'b1;
          core_rst_d = 1'b0;
        end
        if (bus.start) begin
          state_d    = S_HDR0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          core_rst_d = 1'b1;
          word_idx_d = '0;
          byte_idx_d = '0;
          csum_d     = '0;
        end
      end
      S_HDR0: begin
        if (accept) begin
          count_d[7:0] = bus.byte_in;
          csum_d       = csum_q ^ bus.byte_in;
          state_d      = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept) begin
          count_d = hdr_count;
          csum_d  = csum_q ^ bus.byte_in;
          if (32'(hdr_count) > DEPTH) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else if (hdr_count == 16'd0) begin
            state_d = S_FIN;
`ifndef IMEM_BOOT_CHECKSUM_EN
            done_d     = 1'b1;
            core_rst_d = 1'b0;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d     = csum_q ^ bus.byte_in;
          byte_idx_d = byte_idx_q + 2'd1;
          shift_d    = {bus.byte_in, shift_q[23:8]};
          if (byte_idx_q == 2'd3) begin
            we_d       = 1'b1;
            wdata_d    = {bus.byte_in, shift_q};
            addr_d     = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
            word_idx_d = word_idx_q + 16'd1;
            if (word_idx_q == count_q - 16'd1) state_d = S_FIN;
          end
        end
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      S_CSUM: begin
        if (accept) begin
          if (bus.byte_in == csum_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            core_rst_d = 1'b0;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    byte_ready_d = (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_DATA)
`ifdef IMEM_BOOT_CHECKSUM_EN
                   || (state_d == S_CSUM)
`endif
                   ;
  end

  // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      shift_q      <= '0;
      byte_ready_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= BASE_ADDR;
      wdata_q      <= '0;
      core_rst_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      csum_q       <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      shift_q      <= shift_d;
      byte_ready_q <= byte_ready_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      core_rst_q   <= core_rst_d;
      done_q       <= done_d;
      error_q      <= error_d;
      csum_q       <= csum_d;
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.core_rst   = core_rst_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule
